// File: rtl/operand_fetch_if.sv
// Decode-side and execute-side handshake bundle for the operand fetch stage.
// The master drives instructions and consumes operands; the slave is the stage itself.
interface operand_fetch_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [5*NUM_SRC-1:0]      in_rs;
    logic [NUM_SRC-1:0]        in_rs_used;
    logic [XLEN*NUM_SRC-1:0]   reg_rd_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN*NUM_SRC-1:0]   out_data;

    modport master (
        output in_valid, in_rs, in_rs_used, reg_rd_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_rs, in_rs_used, reg_rd_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/operand_fetch.sv
// Register-read stage: resolves each source operand from the register file or the
// rr/ex/mem forwarding paths, stalls when no path can supply it, keeps hazard stats.
module operand_fetch #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    operand_fetch_if.slave    bus,
    input  logic [6:0]        rr_opcode,
    input  logic [6:0]        ex_opcode,
    input  logic [6:0]        mem_opcode,
    input  logic [4:0]        rr_rd,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        mem_rd,
    input  logic [XLEN-1:0]   rr_imm,
    input  logic [XLEN-1:0]   ex_imm,
    input  logic [XLEN-1:0]   mem_imm,
    input  logic [XLEN-1:0]   ex_res,
    input  logic [XLEN-1:0]   mem_res,
    input  logic [XLEN-1:0]   mem_load_data,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  hazard_events
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    // Opcodes whose ALU result is the value written to rd.
    function automatic logic is_alu_result(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_JAL) ||
               (opc == OPC_JALR) || (opc == OPC_AUIPC);
    endfunction

    logic [XLEN-1:0]        slot_data [NUM_SRC];
    logic [NUM_SRC-1:0]     slot_stall;
    logic [XLEN*NUM_SRC-1:0] resolved;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            logic [4:0]      slot_rs;
            logic [XLEN-1:0] slot_rf;

            assign slot_rs = bus.in_rs[5*gi +: 5];
            assign slot_rf = bus.reg_rd_data[XLEN*gi +: XLEN];

            // Youngest matching stage wins; older matches are deliberately ignored.
            always_comb begin
                slot_data[gi]  = slot_rf;
                slot_stall[gi] = 1'b0;
                if (bus.in_valid && bus.in_rs_used[gi] && (slot_rs != 5'd0)) begin
                    if (rr_rd == slot_rs) begin
                        if (rr_opcode == OPC_LUI) slot_data[gi] = rr_imm;
                        else                      slot_stall[gi] = 1'b1;
                    end else if (ex_rd == slot_rs) begin
                        if (ex_opcode == OPC_LUI)          slot_data[gi] = ex_imm;
                        else if (is_alu_result(ex_opcode)) slot_data[gi] = ex_res;
                        else                               slot_stall[gi] = 1'b1;
                    end else if (mem_rd == slot_rs) begin
                        if (mem_opcode == OPC_LUI)          slot_data[gi] = mem_imm;
                        else if (is_alu_result(mem_opcode)) slot_data[gi] = mem_res;
                        else if (mem_opcode == OPC_LOAD)    slot_data[gi] = mem_load_data;
                        else                                slot_stall[gi] = 1'b1;
                    end
                end
            end

            assign resolved[XLEN*gi +: XLEN] = slot_data[gi];
        end
    endgenerate

    logic                     out_valid_reg;
    logic [XLEN*NUM_SRC-1:0]  out_data_reg;
    logic [CNT_W-1:0]         stall_cycles_reg;
    logic [CNT_W-1:0]         hazard_events_reg;
    logic                     stall_prev_reg;
    logic                     accept;

    assign stall        = |slot_stall;
    assign bus.in_ready = !stall && (!out_valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= resolved;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_reg  <= '0;
            hazard_events_reg <= '0;
            stall_prev_reg    <= 1'b0;
        end else begin
            stall_prev_reg <= stall;
            if (stall && (stall_cycles_reg != '1))
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            if (stall && !stall_prev_reg && (hazard_events_reg != '1))
                hazard_events_reg <= hazard_events_reg + 1'b1;
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.out_data   = out_data_reg;
    assign stall_cycles   = stall_cycles_reg;
    assign hazard_events  = hazard_events_reg;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench: a 2-slot/32-bit/2-bit-counter instance for the main scenarios and
// a 3-slot/64-bit instance for load-use forwarding on the last slot.
module tb_operand_fetch;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] OP   = 7'b0110011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] LOAD = 7'b0000011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- instance A: XLEN=32, NUM_SRC=2, CNT_W=2 ----------------
    operand_fetch_if #(.XLEN(32), .NUM_SRC(2)) bus_a ();
    logic [6:0]  a_rr_op, a_ex_op, a_mem_op;
    logic [4:0]  a_rr_rd, a_ex_rd, a_mem_rd;
    logic [31:0] a_rr_imm, a_ex_imm, a_mem_imm, a_ex_res, a_mem_res, a_mem_ld;
    logic        a_stall;
    logic [1:0]  a_sc, a_he;

    operand_fetch #(.XLEN(32), .NUM_SRC(2), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .rr_opcode(a_rr_op), .ex_opcode(a_ex_op), .mem_opcode(a_mem_op),
        .rr_rd(a_rr_rd), .ex_rd(a_ex_rd), .mem_rd(a_mem_rd),
        .rr_imm(a_rr_imm), .ex_imm(a_ex_imm), .mem_imm(a_mem_imm),
        .ex_res(a_ex_res), .mem_res(a_mem_res), .mem_load_data(a_mem_ld),
        .stall(a_stall), .stall_cycles(a_sc), .hazard_events(a_he)
    );

    // ---------------- instance B: XLEN=64, NUM_SRC=3, CNT_W=16 ----------------
    operand_fetch_if #(.XLEN(64), .NUM_SRC(3)) bus_b ();
    logic [6:0]  b_rr_op, b_ex_op, b_mem_op;
    logic [4:0]  b_rr_rd, b_ex_rd, b_mem_rd;
    logic [63:0] b_rr_imm, b_ex_imm, b_mem_imm, b_ex_res, b_mem_res, b_mem_ld;
    logic        b_stall;
    logic [15:0] b_sc, b_he;

    operand_fetch #(.XLEN(64), .NUM_SRC(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .rr_opcode(b_rr_op), .ex_opcode(b_ex_op), .mem_opcode(b_mem_op),
        .rr_rd(b_rr_rd), .ex_rd(b_ex_rd), .mem_rd(b_mem_rd),
        .rr_imm(b_rr_imm), .ex_imm(b_ex_imm), .mem_imm(b_mem_imm),
        .ex_res(b_ex_res), .mem_res(b_mem_res), .mem_load_data(b_mem_ld),
        .stall(b_stall), .stall_cycles(b_sc), .hazard_events(b_he)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_rr_op = '0; a_ex_op = '0; a_mem_op = '0;
        a_rr_rd = '0; a_ex_rd = '0; a_mem_rd = '0;
        a_rr_imm = '0; a_ex_imm = '0; a_mem_imm = '0;
        a_ex_res = '0; a_mem_res = '0; a_mem_ld = '0;
    endtask

    initial begin
        idle_a();
        b_rr_op = '0; b_ex_op = '0; b_mem_op = '0;
        b_rr_rd = '0; b_ex_rd = '0; b_mem_rd = '0;
        b_rr_imm = '0; b_ex_imm = '0; b_mem_imm = '0;
        b_ex_res = '0; b_mem_res = '0; b_mem_ld = '0;
        bus_a.in_valid = 0; bus_a.in_rs = '0; bus_a.in_rs_used = '0;
        bus_a.reg_rd_data = '0; bus_a.out_ready = 1;
        bus_b.in_valid = 0; bus_b.in_rs = '0; bus_b.in_rs_used = '0;
        bus_b.reg_rd_data = '0; bus_b.out_ready = 1;

        tick(); tick();
        rst = 0;
        check("reset out_valid", 64'(bus_a.out_valid), 64'd0);
        check("reset out_data", 64'(bus_a.out_data), 64'd0);
        check("reset stall_cycles", 64'(a_sc), 64'd0);
        check("reset hazard_events", 64'(a_he), 64'd0);

        // Wide build: load-use on slot 2, then forwarded from mem load data.
        bus_b.in_valid = 1;
        bus_b.in_rs = {5'd5, 5'd0, 5'd0};
        bus_b.in_rs_used = 3'b111;
        bus_b.reg_rd_data = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        b_ex_op = LOAD; b_ex_rd = 5'd5;
        #1;
        check("b load-use stall", 64'(b_stall), 64'd1);
        check("b load-use in_ready", 64'(bus_b.in_ready), 64'd0);
        tick();
        b_mem_op = LOAD; b_mem_rd = 5'd5; b_mem_ld = 64'hDEAD_BEEF_0BAD_F00D; b_ex_rd = 5'd0;
        #1;
        check("b mem fwd stall", 64'(b_stall), 64'd0);
        tick();
        bus_b.in_valid = 0;
        check("b out_valid", 64'(bus_b.out_valid), 64'd1);
        check("b slot2 load data", bus_b.out_data[128 +: 64], 64'hDEAD_BEEF_0BAD_F00D);
        check("b slot0 regfile", bus_b.out_data[0 +: 64], 64'h1111_1111_1111_1111);

        // Load-use on slot 1.
        bus_a.in_valid = 1;
        bus_a.in_rs = {5'd5, 5'd0};
        bus_a.in_rs_used = 2'b11;
        bus_a.reg_rd_data = {32'h1111_1111, 32'hAAAA_0000};
        a_ex_op = LOAD; a_ex_rd = 5'd5;
        #1;
        check("load-use stall", 64'(a_stall), 64'd1);
        check("load-use in_ready", 64'(bus_a.in_ready), 64'd0);
        tick();
        a_mem_op = LOAD; a_mem_rd = 5'd5; a_mem_ld = 32'hDEAD_BEEF; a_ex_rd = 5'd0;
        #1;
        check("mem load fwd in_ready", 64'(bus_a.in_ready), 64'd1);
        tick();
        check("load fwd out_valid", 64'(bus_a.out_valid), 64'd1);
        check("load fwd slot1", 64'(bus_a.out_data[63:32]), 64'hDEAD_BEEF);
        check("load fwd slot0", 64'(bus_a.out_data[31:0]), 64'hAAAA_0000);
        check("load-use stall_cycles", 64'(a_sc), 64'd1);
        check("load-use hazard_events", 64'(a_he), 64'd1);

        // Priority: rr LUI wins over matching ex/mem.
        idle_a();
        bus_a.in_rs = {5'd0, 5'd3};
        bus_a.in_rs_used = 2'b01;
        a_rr_rd = 5'd3; a_ex_rd = 5'd3; a_mem_rd = 5'd3;
        a_rr_op = LUI; a_rr_imm = 32'h1234_5000;
        a_ex_op = OP; a_ex_res = 32'h0BAD_0001;
        a_mem_op = LOAD; a_mem_ld = 32'h0BAD_0002;
        #1;
        check("prio rr lui stall", 64'(a_stall), 64'd0);
        tick();
        check("prio rr lui slot0", 64'(bus_a.out_data[31:0]), 64'h1234_5000);
        a_rr_op = OP;
        #1;
        check("prio rr op stall", 64'(a_stall), 64'd1);
        tick();
        check("stall drains out_valid", 64'(bus_a.out_valid), 64'd0);
        check("second hazard event", 64'(a_he), 64'd2);

        // ex ALU forward, then mem JAL forward.
        a_rr_rd = 5'd0; a_ex_res = 32'hCAFE_0001;
        tick();
        check("ex op fwd slot0", 64'(bus_a.out_data[31:0]), 64'hCAFE_0001);
        a_ex_rd = 5'd0; a_mem_op = JAL; a_mem_res = 32'h0000_0444;
        tick();
        check("mem jal fwd slot0", 64'(bus_a.out_data[31:0]), 64'h0000_0444);

        // x0 and an unused slot never stall, even against an ex load.
        idle_a();
        bus_a.in_rs = {5'd7, 5'd0};
        bus_a.in_rs_used = 2'b01;
        bus_a.reg_rd_data = {32'h7777_7777, 32'h0000_00AA};
        a_ex_op = LOAD; a_ex_rd = 5'd7;
        #1;
        check("x0/unused stall", 64'(a_stall), 64'd0);
        tick();
        check("x0/unused data", 64'(bus_a.out_data), 64'h7777_7777_0000_00AA);

        // Both slots name the same register.
        idle_a();
        bus_a.in_rs = {5'd9, 5'd9};
        bus_a.in_rs_used = 2'b11;
        a_mem_op = OP; a_mem_rd = 5'd9; a_mem_res = 32'h0000_0099;
        tick();
        check("same reg both slots", 64'(bus_a.out_data), 64'h0000_0099_0000_0099);

        // Backpressure: A held in the output while B waits upstream.
        idle_a();
        bus_a.in_valid = 0;
        tick();
        bus_a.in_valid = 1;
        bus_a.in_rs = '0;
        bus_a.in_rs_used = 2'b11;
        bus_a.reg_rd_data = {32'hA1A1_A1A1, 32'hA0A0_A0A0};
        bus_a.out_ready = 0;
        tick();
        bus_a.reg_rd_data = {32'hB1B1_B1B1, 32'hB0B0_B0B0};
        for (int i = 0; i < 3; i++) begin
            check("bp in_ready", 64'(bus_a.in_ready), 64'd0);
            check("bp stall", 64'(a_stall), 64'd0);
            check("bp out_data A", 64'(bus_a.out_data), 64'hA1A1_A1A1_A0A0_A0A0);
            check("bp out_valid", 64'(bus_a.out_valid), 64'd1);
            tick();
        end
        bus_a.out_ready = 1;
        #1;
        check("bp release in_ready", 64'(bus_a.in_ready), 64'd1);
        tick();
        check("bp B out_valid", 64'(bus_a.out_valid), 64'd1);
        check("bp B out_data", 64'(bus_a.out_data), 64'hB1B1_B1B1_B0B0_B0B0);
        bus_a.in_valid = 0;
        tick();
        check("bp drained", 64'(bus_a.out_valid), 64'd0);

        // Counters: reset (overriding a stall) then 5 consecutive stall cycles.
        rst = 1;
        bus_a.in_valid = 1;
        bus_a.in_rs = {5'd0, 5'd4};
        bus_a.in_rs_used = 2'b01;
        a_rr_rd = 5'd4; a_rr_op = OP;
        tick();
        rst = 0;
        check("cnt cleared sc", 64'(a_sc), 64'd0);
        check("cnt cleared he", 64'(a_he), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("sat stall_cycles", 64'(a_sc), 64'd3);
        check("sat hazard_events", 64'(a_he), 64'd1);

        // Two separate one-cycle stalls, second one under backpressure.
        rst = 1;
        tick();
        rst = 0;
        tick();
        a_rr_op = LUI; a_rr_imm = 32'h0000_4000;
        bus_a.out_ready = 0;
        tick();
        check("mid accept slot0", 64'(bus_a.out_data[31:0]), 64'h0000_4000);
        a_rr_op = OP;
        tick();
        check("two stalls hazard_events", 64'(a_he), 64'd2);
        check("two stalls stall_cycles", 64'(a_sc), 64'd2);
        check("hazard+bp out_valid", 64'(bus_a.out_valid), 64'd1);
        check("hazard+bp out_data", 64'(bus_a.out_data[31:0]), 64'h0000_4000);

        // Reset in mid-stall with a valid output.
        rst = 1;
        tick();
        rst = 0;
        check("rst out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst out_data", 64'(bus_a.out_data), 64'd0);
        check("rst stall_cycles", 64'(a_sc), 64'd0);
        check("rst hazard_events", 64'(a_he), 64'd0);
        tick();
        check("post-rst new event", 64'(a_he), 64'd1);
        check("post-rst stall_cycles", 64'(a_sc), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
